temp_bcd_encoder: RTL
=====================

# temp_bcd_encoder

Sequential producer for the two-digit BCD temperature bus consumed by the temperature-state classifier. Accepts a signed two's-complement temperature sample through a valid/ready handshake, clamps its magnitude to 0..99, and converts it to tens/units BCD with an iterative shift-add-3 (double-dabble) engine. Also reports sign, overflow and a sign-change pulse, so the classifier can escalate on polarity flips.

## Interface
- WIDTH, 8 — sample width in bits, two's complement; legal range 8..16
- MAX_MAG, 99 — clamp limit for the magnitude; fixed by the two-digit display
- clk  input  1  — rising-edge clock
- rst_n  input  1  — asynchronous, active-low reset; one clock domain only
- sample  input  WIDTH  — signed temperature sample
- sample_valid  input  1  — sample is present
- sample_ready  output  1  — block is idle; high exactly when the FSM is in IDLE, including while rst_n is low
- bcd_tens  output  4  — tens digit, 0..9
- bcd_units  output  4  — units digit, 0..9
- sign  output  1  — 1 = negative committed sample; zero counts as positive
- overflow  output  1  — committed magnitude was clamped to MAX_MAG
- bcd_valid  output  1  — one-cycle pulse when the digit outputs update
- sign_change  output  1  — one-cycle pulse, coincident with bcd_valid, when the new sign differs from the previously committed sign

## Operation
- States: IDLE, CLAMP, SHIFT.
- IDLE:
  - A sample is accepted on a clock edge where sample_valid and sample_ready are both high. The sample is latched and the FSM moves to CLAMP.
  - sample_valid is ignored in any other state; no queuing.
- CLAMP, one cycle:
  - mag = |sample|; the most negative value, e.g. -128, gives 128, computed in WIDTH+1 bits.
  - If mag > MAX_MAG: mag = MAX_MAG and ovf_pend = 1.
  - Load the 7-bit mag into the shift register and clear the 8-bit BCD accumulator. Go to SHIFT with count = 0.
- SHIFT, 7 cycles:
  - Each cycle, every BCD digit that is ≥5 gets +3 added first.
  - Then the {bcd, mag} register shifts left by one.
  - count increments; after the 7th shift the FSM returns to IDLE.
- Commit, on the edge that ends the 7th shift:
  - bcd_tens and bcd_units update.
  - sign, overflow and bcd_valid = 1 update.
  - sign_change = (new sign != previous committed sign).
- Outputs hold their values between commits. bcd_valid and sign_change are 0 on every cycle other than the commit cycle.
- The first conversion after reset compares its sign against the reset value 0.
- Reset, asserted at any time, including mid-conversion:
  - Aborts the conversion and returns the FSM to IDLE.
  - bcd_tens = 0, bcd_units = 0, sign = 0, overflow = 0, bcd_valid = 0, sign_change = 0; no partial result is ever committed.
  - sample_ready = 1.

## Timing
- Accept edge E0 → CLAMP during E0..E1 → shifts on edges E2..E8 → outputs and bcd_valid visible after E8. Latency is 8 cycles from accept to bcd_valid.
- sample_ready is high again in the cycle in which bcd_valid is high. A sample accepted on edge E9 starts back-to-back conversions, giving a throughput of one sample per 9 cycles.
- sample_ready falls in the cycle after the accept edge and stays low for 8 cycles.
- Latency does not depend on the data value: clamp, zero and negative inputs all take 8 cycles.

## Structure
- Shared package temp_pkg:
  - State encoding localparams IDLE/CLAMP/SHIFT.
  - MAX_MAG = 99.
  - SHIFT_CNT = 7.
  - BCD digit width 4.
  - The classifier consumes the same package.
- Sub-module bcd_add3: combinational digit correction (in ≥5 → in+3). Instantiated twice, once per digit.
- Everything else lives in the top module: FSM, counter, shift register, output registers.

## Test plan
- Reset low mid-SHIFT after sample=47 is accepted → all outputs 0, sample_ready = 1. After release, no bcd_valid is seen until a new sample is accepted.
- sample=8'd47 accepted at E0 → bcd_valid only at E8 with tens=4, units=7, sign=0, overflow=0, sign_change=0.
- sample=8'd0, then 8'd99 back-to-back (second accepted in the bcd_valid cycle) → digits 0/0, then 9/9. Commits are exactly 9 cycles apart and overflow stays 0.
- sample=8'd120, then 8'h80 (-128) → both give tens=9, units=9, overflow=1. The second also gives sign=1 and sign_change=1.
- sample=-5 (8'hFB), then +5, then +5 → digits 0/5 each time. sign_change is 1 on the first commit, 1 on the second, and 0 on the third.
- sample_valid toggled while sample_ready=0 → sample is ignored; the committed digits match the originally accepted sample.

Source files
------------

// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared encodings and limits for the temperature BCD path
package temp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLAMP = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int MAX_MAG   = 99;
  localparam int SHIFT_CNT = 7;
  localparam int DIGIT_W   = 4;
  localparam int BIN_W     = 7;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction, adds 3 to digits of 5 or more
module bcd_add3
  import temp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= DIGIT_W'(5)) corrected = digit + DIGIT_W'(3);
  end

endmodule

// File: rtl/temp_bcd_encoder.sv
// rtl/temp_bcd_encoder.sv - signed sample to clamped two-digit BCD with sign/overflow/sign-change
module temp_bcd_encoder
  import temp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sample,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic [DIGIT_W-1:0] bcd_tens,
  output logic [DIGIT_W-1:0] bcd_units,
  output logic               sign,
  output logic               overflow,
  output logic               bcd_valid,
  output logic               sign_change
);

  localparam logic [WIDTH:0] MAG_LIMIT = (WIDTH+1)'(MAX_MAG);

  state_t               state, next_state;
  logic [WIDTH-1:0]     sample_q;
  logic [2:0]           count;
  logic [2*DIGIT_W-1:0] bcd;
  logic [BIN_W-1:0]     bin;
  logic                 sign_pend;
  logic                 ovf_pend;

  logic [WIDTH:0]       sext;
  logic [WIDTH:0]       mag_full;
  logic                 clamp_hit;
  logic [BIN_W-1:0]     mag_clamped;
  logic [DIGIT_W-1:0]   tens_fix;
  logic [DIGIT_W-1:0]   units_fix;
  logic [2*DIGIT_W-1:0] bcd_next;
  logic [BIN_W-1:0]     bin_next;
  logic                 last_shift;

  bcd_add3 u_add3_tens  (.digit(bcd[2*DIGIT_W-1:DIGIT_W]), .corrected(tens_fix));
  bcd_add3 u_add3_units (.digit(bcd[DIGIT_W-1:0]),         .corrected(units_fix));

  // One extra bit so the most negative sample negates without wrapping.
  always_comb begin
    sext        = {sample_q[WIDTH-1], sample_q};
    mag_full    = sample_q[WIDTH-1] ? -sext : sext;
    clamp_hit   = mag_full > MAG_LIMIT;
    mag_clamped = clamp_hit ? MAG_LIMIT[BIN_W-1:0] : mag_full[BIN_W-1:0];
    {bcd_next, bin_next} = {tens_fix, units_fix, bin} << 1;
    last_shift  = (state == SHIFT) && (count == 3'(SHIFT_CNT - 1));
  end

  assign sample_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = CLAMP;
      CLAMP:   next_state = SHIFT;
      SHIFT:   if (last_shift) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      count       <= '0;
      bcd         <= '0;
      bin         <= '0;
      sign_pend   <= 1'b0;
      ovf_pend    <= 1'b0;
      bcd_tens    <= '0;
      bcd_units   <= '0;
      sign        <= 1'b0;
      overflow    <= 1'b0;
      bcd_valid   <= 1'b0;
      sign_change <= 1'b0;
    end else begin
      bcd_valid   <= 1'b0;
      sign_change <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) sample_q <= sample;
        end
        CLAMP: begin
          bin       <= mag_clamped;
          bcd       <= '0;
          count     <= '0;
          sign_pend <= sample_q[WIDTH-1];
          ovf_pend  <= clamp_hit;
        end
        SHIFT: begin
          bcd   <= bcd_next;
          bin   <= bin_next;
          count <= count + 3'd1;
          if (last_shift) begin
            bcd_tens    <= bcd_next[2*DIGIT_W-1:DIGIT_W];
            bcd_units   <= bcd_next[DIGIT_W-1:0];
            sign        <= sign_pend;
            overflow    <= ovf_pend;
            bcd_valid   <= 1'b1;
            sign_change <= sign_pend ^ sign;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
